// File: rtl/l2_mem_responder.sv
// l2_mem_responder: line-granular main memory serving L2 fills and write-backs with programmable latency
// Ports:
//   clk, nrst                 clock, synchronous active-low reset
//   read_L2_MEM/write_L2_MEM  level requests held until ready_MEM_L2
//   index/tag/write_tag       line address of the read and of the write-back (shared index)
//   write_data_L2_MEM         write-back line, read_data_MEM_L2 fill line (held after ready)
//   ready_MEM_L2              one-cycle completion pulse
//   init_wen/addr/data        word preload port, honoured only while idle with no request
//   busy                      high whenever a transaction is in progress
module l2_mem_responder #(
  parameter int LINE_ADDR_W = 10,
  parameter int RD_LATENCY  = 4,
  parameter int WR_LATENCY  = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   read_L2_MEM,
  input  logic                   write_L2_MEM,
  input  logic [7:0]             index_L2_MEM,
  input  logic [17:0]            tag_L2_MEM,
  input  logic [17:0]            write_tag_L2_MEM,
  input  logic [511:0]           write_data_L2_MEM,
  output logic                   ready_MEM_L2,
  output logic [511:0]           read_data_MEM_L2,
  input  logic                   init_wen,
  input  logic [LINE_ADDR_W+3:0] init_addr,
  input  logic [31:0]            init_data,
  output logic                   busy
);
  localparam int MAXL = RD_LATENCY > WR_LATENCY ? RD_LATENCY : WR_LATENCY;
  localparam int CW = $clog2(MAXL + 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;
  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic                     rd_q;
  logic [7:0]               idx_q;
  logic [17:0]              tag_q, wtag_q;
  logic [511:0]             wdata_q;
  logic [511:0]             mem_q [2**LINE_ADDR_W];
  logic [LINE_ADDR_W-1:0]   rd_line, wr_line;
  logic                     commit, preload;
  // truncating {tag, index} keeps only the low tag bits, so upper tag bits alias
  assign rd_line = LINE_ADDR_W'({tag_q, idx_q});
  assign wr_line = LINE_ADDR_W'({wtag_q, idx_q});
  assign busy    = state_q != IDLE;
  assign commit  = nrst && state_q == WRITE && cnt_q == '0;
  assign preload = nrst && state_q == IDLE && !read_L2_MEM && !write_L2_MEM && init_wen;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      ready_MEM_L2     <= 1'b0;
      read_data_MEM_L2 <= '0;
    end else begin
      ready_MEM_L2 <= 1'b0;
      case (state_q)
        IDLE: if (read_L2_MEM || write_L2_MEM) begin
          rd_q    <= read_L2_MEM;
          idx_q   <= index_L2_MEM;
          tag_q   <= tag_L2_MEM;
          wtag_q  <= write_tag_L2_MEM;
          wdata_q <= write_data_L2_MEM;
          state_q <= write_L2_MEM ? WRITE : READ;
          cnt_q   <= write_L2_MEM ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1);
        end
        WRITE: if (cnt_q == '0) begin
          state_q      <= rd_q ? READ : RESP;
          ready_MEM_L2 <= !rd_q;
          cnt_q        <= CW'(RD_LATENCY - 1);
        end else cnt_q <= cnt_q - 1'b1;
        READ: if (cnt_q == '0) begin
          read_data_MEM_L2 <= mem_q[rd_line];
          state_q          <= RESP;
          ready_MEM_L2     <= 1'b1;
        end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  // storage is never reset; a reset edge blocks both commit and preload
  always_ff @(posedge clk) begin
    if (commit) mem_q[wr_line] <= wdata_q;
    else if (preload) mem_q[init_addr[LINE_ADDR_W+3:4]][{init_addr[3:0], 5'b0} +: 32] <= init_data;
  end
endmodule

// File: tb/tb_l2_mem_responder.sv
// tb_l2_mem_responder: directed self-checking bench for l2_mem_responder
module tb_l2_mem_responder;
  logic         clk = 0;
  logic         nrst = 0;
  logic         rd = 0, wr = 0;
  logic [7:0]   idx = 0;
  logic [17:0]  tag = 0, wtag = 0;
  logic [511:0] wdata = 0;
  logic         ready;
  logic [511:0] rdata;
  logic         init_wen = 0;
  logic [13:0]  init_addr = 0;
  logic [31:0]  init_data = 0;
  logic         busy;
  int           passed = 0, total = 0;
  logic [511:0] line5, line310;
  l2_mem_responder dut (
    .clk(clk), .nrst(nrst), .read_L2_MEM(rd), .write_L2_MEM(wr),
    .index_L2_MEM(idx), .tag_L2_MEM(tag), .write_tag_L2_MEM(wtag),
    .write_data_L2_MEM(wdata), .ready_MEM_L2(ready), .read_data_MEM_L2(rdata),
    .init_wen(init_wen), .init_addr(init_addr), .init_data(init_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    init_wen = 1; init_addr = a; init_data = d;
    @(negedge clk);
    init_wen = 0;
  endtask
  // drives one request, pulses init_wen at cycle init_k (0 = same edge as the request),
  // returns edges from the sampling edge to ready, or -1 on timeout; returns in the ready cycle
  task automatic do_req(input logic r, w, input logic [7:0] i, input logic [17:0] t, wt,
                        input logic [511:0] wd, input int init_k, input logic [13:0] ia,
                        input logic [31:0] id, input bit hold, output int lat);
    @(negedge clk);
    rd = r; wr = w; idx = i; tag = t; wtag = wt; wdata = wd;
    init_addr = ia; init_data = id; init_wen = init_k == 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      init_wen = k == init_k;
      if (ready) begin lat = k - 1; break; end
    end
    init_wen = 0;
    if (!hold) begin rd = 0; wr = 0; end
  endtask
  task automatic test_reset;
    nrst = 0;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready); else passed++;
    total++; if (rdata !== '0) $display("FAIL reset_data got %h want 0", rdata); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    nrst = 1;
  endtask
  task automatic test_read;
    int lat;
    for (int w = 0; w < 16; w++) begin
      preload({10'h005, 4'(w)}, 32'h1000_0000 + w);
      line5[32*w +: 32] = 32'h1000_0000 + w;
    end
    for (int w = 0; w < 16; w++) line310[32*w +: 32] = 32'h3100_0000 + w;
    for (int w = 0; w < 16; w++) preload({10'h310, 4'(w)}, line310[32*w +: 32]);
    do_req(1, 0, 8'h05, 18'h0, 18'h0, '0, -1, 0, 0, 0, lat);
    total++; if (lat !== 4) $display("FAIL read_latency got %0d want 4", lat); else passed++;
    total++; if (rdata !== line5) $display("FAIL read_data got %h want %h", rdata, line5); else passed++;
    @(negedge clk);
    total++; if (ready !== 1'b0) $display("FAIL read_ready_width got %b want 0", ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL read_busy_after got %b want 0", busy); else passed++;
  endtask
  task automatic test_write;
    int lat;
    logic [511:0] prev;
    prev = rdata;
    do_req(0, 1, 8'h22, 18'h0, 18'h1, {64{8'hA5}}, -1, 0, 0, 0, lat);
    total++; if (lat !== 4) $display("FAIL write_latency got %0d want 4", lat); else passed++;
    total++; if (rdata !== prev) $display("FAIL write_keeps_data got %h want %h", rdata, prev); else passed++;
    do_req(1, 0, 8'h22, 18'h1, 18'h0, '0, -1, 0, 0, 0, lat);
    total++; if (rdata !== {64{8'hA5}}) $display("FAIL write_readback got %h want a5..", rdata); else passed++;
  endtask
  task automatic test_combined;
    int lat;
    do_req(1, 1, 8'h10, 18'h3, 18'h2, {16{32'hBEEF_0002}}, -1, 0, 0, 0, lat);
    total++; if (lat !== 8) $display("FAIL comb_latency got %0d want 8", lat); else passed++;
    total++; if (rdata !== line310) $display("FAIL comb_old_data got %h want %h", rdata, line310); else passed++;
    do_req(1, 0, 8'h10, 18'h2, 18'h0, '0, -1, 0, 0, 0, lat);
    total++; if (rdata !== {16{32'hBEEF_0002}}) $display("FAIL comb_commit got %h want beef0002..", rdata); else passed++;
    do_req(1, 1, 8'h10, 18'h3, 18'h3, {16{32'h5A5A_0033}}, -1, 0, 0, 0, lat);
    total++; if (lat !== 8) $display("FAIL comb_same_latency got %0d want 8", lat); else passed++;
    total++; if (rdata !== {16{32'h5A5A_0033}}) $display("FAIL comb_same_data got %h want 5a5a0033..", rdata); else passed++;
  endtask
  task automatic test_reset_mid_write;
    int lat;
    @(negedge clk);
    wr = 1; idx = 8'h22; wtag = 18'h1; wdata = {16{32'hDEAD_0001}};
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL midwr_busy got %b want 1", busy); else passed++;
    nrst = 0; wr = 0;
    repeat (2) begin
      @(negedge clk);
      total++; if (ready !== 1'b0 || rdata !== '0 || busy !== 1'b0)
        $display("FAIL midwr_reset got ready=%b busy=%b data=%h want 0/0/0", ready, busy, rdata); else passed++;
    end
    nrst = 1;
    repeat (4) @(negedge clk);
    total++; if (ready !== 1'b0) $display("FAIL midwr_no_ready got %b want 0", ready); else passed++;
    do_req(1, 0, 8'h22, 18'h1, 18'h0, '0, -1, 0, 0, 0, lat);
    total++; if (rdata !== {64{8'hA5}}) $display("FAIL midwr_no_commit got %h want a5..", rdata); else passed++;
  endtask
  task automatic test_init_drop;
    int lat;
    do_req(1, 0, 8'h05, 18'h0, 18'h0, '0, 2, {10'h005, 4'h0}, 32'hFFFF_FFFF, 0, lat);
    total++; if (rdata !== line5) $display("FAIL drop_busy_read got %h want %h", rdata, line5); else passed++;
    do_req(1, 0, 8'h05, 18'h0, 18'h0, '0, 0, {10'h005, 4'h1}, 32'hEEEE_EEEE, 0, lat);
    total++; if (lat !== 4) $display("FAIL drop_req_latency got %0d want 4", lat); else passed++;
    total++; if (rdata !== line5) $display("FAIL drop_req_read got %h want %h", rdata, line5); else passed++;
    do_req(1, 0, 8'h05, 18'h0, 18'h0, '0, -1, 0, 0, 0, lat);
    total++; if (rdata !== line5) $display("FAIL drop_readback got %h want %h", rdata, line5); else passed++;
  endtask
  task automatic test_alias_hold;
    int lat;
    do_req(0, 1, 8'h33, 18'h0, 18'h004, {16{32'hCAFE_0004}}, -1, 0, 0, 0, lat);
    do_req(1, 0, 8'h33, 18'h3FC, 18'h0, '0, -1, 0, 0, 1, lat);
    total++; if (lat !== 4) $display("FAIL alias_latency got %0d want 4", lat); else passed++;
    total++; if (rdata !== {16{32'hCAFE_0004}}) $display("FAIL alias_data got %h want cafe0004..", rdata); else passed++;
    @(negedge clk);
    total++; if (ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL hold_not_reserved got ready=%b busy=%b want 0/0", ready, busy); else passed++;
    rd = 0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL hold_idle got %b want 0", busy); else passed++;
  endtask
  initial begin
    test_reset;
    test_read;
    test_write;
    test_combined;
    test_reset_mid_write;
    test_init_drop;
    test_alias_hold;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
